// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and output-stream signals of the ALU sequencer, bundled for port use.
// The sequencer connects through the slave modport; the environment uses master.
interface alu_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned CNT_W   = 8;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [OP_W-1:0]    alu_opcode;
  logic [DATA_W-1:0]  alu_result;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               zero_flag;
  logic [CNT_W-1:0]   instr_count;

  modport slave (
    input  in_valid, in_instr, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_opcode, out_valid, out_data, zero_flag, instr_count
  );

  modport master (
    output in_valid, in_instr, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_opcode, out_valid, out_data, zero_flag, instr_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control side of an 8-bit ALU: decodes handshaked instructions, feeds registered operands,
// writes the ALU result back into a small register file and streams registers out.
module alu_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);
  localparam int unsigned REG_W = $clog2(NREGS);
  localparam int unsigned OP_W  = 3;
  localparam int unsigned IMM_W = 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] OP_LOADI = 3'b110;
  localparam logic [OP_W-1:0] OP_OUT   = 3'b111;
  localparam logic [OP_W-1:0] ALU_NOP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic             rsvd;
    logic [IMM_W-1:0] imm;
  } instr_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;

  instr_t instr;
  logic   accept;
  logic   rsvd_unused;

  assign instr       = instr_t'(bus.in_instr);
  assign accept      = (state_q == S_IDLE) && bus.in_valid;
  assign rsvd_unused = instr.rsvd;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (instr.op == OP_OUT) ? S_OUT : S_EXEC;
        end
      end
      S_EXEC: state_d = S_IDLE;
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; in_ready tracks the idle state one-for-one
  always_comb begin
    regs_d      = regs_q;
    rd_d        = rd_q;
    op_d        = op_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
    in_ready_d  = (state_d == S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d     = instr.rd;
          op_d     = instr.op;
          imm_d    = instr.imm;
          alu_a_d  = regs_q[instr.rd];
          alu_b_d  = regs_q[instr.rs];
          alu_op_d = (instr.op == OP_LOADI || instr.op == OP_OUT) ? ALU_NOP : instr.op;
          if (instr.op == OP_OUT) begin
            out_valid_d = 1'b1;
            out_data_d  = regs_q[instr.rd];
          end
        end
      end
      S_EXEC: begin
        if (op_q == OP_LOADI) begin
          regs_d[rd_q] = DATA_W'(imm_q);
        end else begin
          regs_d[rd_q] = bus.alu_result;
          zero_d       = (bus.alu_result == '0);
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      rd_q        <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_NOP;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      regs_q      <= regs_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.zero_flag   = zero_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: an instruction-level model tracks architectural state and expected
// outputs; a per-cycle compare process checks the DUT against it, plus literal spot checks.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();
  alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [2:0] AND_ = 3'd0, OR_ = 3'd1, ADD_ = 3'd2, SUB_ = 3'd3;
  localparam logic [2:0] INC_ = 3'd4, DEC_ = 3'd5, LDI_ = 3'd6, OUT_ = 3'd7;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a + 8'd1;
      3'd5:    return a - 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  // Combinational ALU attached to the sequencer
  always_comb bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // Architectural model and expected output values
  logic [7:0] mregs [4];
  logic       mzero;
  logic [7:0] mcount;
  logic       e_in_ready, e_out_valid;
  logic [7:0] e_out_data, e_a, e_b;
  logic [2:0] e_op;
  logic       chk_en = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check8("in_ready",    8'(bus.in_ready),  8'(e_in_ready));
      check8("out_valid",   8'(bus.out_valid), 8'(e_out_valid));
      check8("zero_flag",   8'(bus.zero_flag), 8'(mzero));
      check8("instr_count", bus.instr_count,   mcount);
      check8("alu_a",       bus.alu_a,         e_a);
      check8("alu_b",       bus.alu_b,         e_b);
      check8("alu_opcode",  8'(bus.alu_opcode), 8'(e_op));
      if (e_out_valid) check8("out_data", bus.out_data, e_out_data);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    mzero       = 1'b0;
    mcount      = 8'd0;
    e_in_ready  = 1'b1;
    e_out_valid = 1'b0;
    e_out_data  = 8'd0;
    e_a         = 8'd0;
    e_b         = 8'd0;
    e_op        = 3'd7;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;
    repeat (cycles - 1) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expectations right after the accepting edge
  task automatic note_accept(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    e_in_ready = 1'b0;
    e_a  = mregs[rd];
    e_b  = mregs[rs];
    e_op = (op >= 3'd6) ? 3'd7 : op;
    if (op == OUT_) begin
      e_out_valid = 1'b1;
      e_out_data  = mregs[rd];
    end
  endtask

  // ALU op or LOADI; called and returns at a falling edge
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, input logic rsvd,
                       output logic [7:0] sa, output logic [7:0] sb, output logic [2:0] sop);
    logic [7:0] r;
    bus.in_instr = {op, rd, rs, rsvd, imm};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    note_accept(op, rd, rs);
    @(negedge clk);
    sa  = bus.alu_a;
    sb  = bus.alu_b;
    sop = bus.alu_opcode;
    @(posedge clk);
    #1;
    if (op < 3'd6) begin
      r = alu_fn(op, mregs[rd], mregs[rs]);
      mregs[rd] = r;
      mzero = (r == 8'd0);
    end else begin
      mregs[rd] = imm;
    end
    mcount++;
    e_in_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic ins(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    logic [7:0] a, b;
    logic [2:0] o;
    issue(op, rd, rs, imm, 1'b0, a, b, o);
  endtask

  // OUT with `w` stall cycles; stray instructions are offered while stalled
  task automatic op_out(input logic [1:0] rd, input int w, output logic [7:0] d);
    bus.in_instr = {OUT_, rd, 2'd0, 1'b0, 8'd0};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    note_accept(OUT_, rd, 2'd0);
    @(negedge clk);
    d = bus.out_data;
    for (int i = 0; i < w; i++) begin
      bus.in_instr = {LDI_, 2'd0, 2'd0, 1'b0, 8'hAA};
      bus.in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    e_out_valid = 1'b0;
    mcount++;
    e_in_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, a, b;
    logic [2:0] o;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_instr  = '0;

    // Reset state
    do_reset(2);
    check8("rst_in_ready",  8'(bus.in_ready),   8'd1);
    check8("rst_opcode",    8'(bus.alu_opcode), 8'd7);
    check8("rst_out_valid", 8'(bus.out_valid),  8'd0);
    check8("rst_count",     bus.instr_count,    8'd0);
    check8("rst_out_data",  bus.out_data,       8'd0);
    for (int r = 0; r < 4; r++) begin
      op_out(2'(r), 0, d);
      check8("rst_reg", d, 8'd0);
    end

    // LOADI / OR / OUT
    do_reset(2);
    ins(LDI_, 2'd0, 2'd0, 8'h0F);
    ins(LDI_, 2'd1, 2'd0, 8'hF0);
    ins(LDI_, 2'd2, 2'd0, 8'h0F);
    ins(OR_,  2'd2, 2'd1, 8'h00);
    check8("or_count", bus.instr_count, 8'd4);
    check8("or_zero",  8'(bus.zero_flag), 8'd0);
    op_out(2'd2, 0, d);
    check8("or_data", d, 8'hFF);

    // SUB r0,r0 with reserved bit set on the LOADI
    issue(LDI_, 2'd0, 2'd3, 8'h05, 1'b1, a, b, o);
    issue(SUB_, 2'd0, 2'd0, 8'h00, 1'b0, a, b, o);
    check8("sub_a",  a, 8'h05);
    check8("sub_b",  b, 8'h05);
    check8("sub_op", 8'(o), 8'd3);
    check8("sub_zero", 8'(bus.zero_flag), 8'd1);
    op_out(2'd0, 0, d);
    check8("sub_r0", d, 8'h00);

    // INC wrap, DEC back, ADD doubling, AND
    ins(LDI_, 2'd3, 2'd0, 8'hFF);
    ins(INC_, 2'd3, 2'd1, 8'h00);
    check8("inc_zero", 8'(bus.zero_flag), 8'd1);
    op_out(2'd3, 0, d);
    check8("inc_wrap", d, 8'h00);
    ins(DEC_, 2'd3, 2'd2, 8'h00);
    op_out(2'd3, 0, d);
    check8("dec_wrap", d, 8'hFF);
    ins(ADD_, 2'd1, 2'd1, 8'h00);
    op_out(2'd1, 0, d);
    check8("add_double", d, 8'hE0);
    ins(AND_, 2'd2, 2'd1, 8'h00);

    // OUT back-pressure with stray instructions offered
    op_out(2'd2, 5, d);
    check8("stall_data", d, 8'hE0);
    op_out(2'd0, 0, d);
    check8("stall_r0_untouched", d, 8'h00);

    // Reset during EXEC of ADD r1,r1
    ins(LDI_, 2'd1, 2'd0, 8'h22);
    bus.in_instr = {ADD_, 2'd1, 2'd1, 1'b0, 8'h00};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    note_accept(ADD_, 2'd1, 2'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check8("xrst_count",    bus.instr_count,  8'd0);
    check8("xrst_in_ready", 8'(bus.in_ready), 8'd1);
    op_out(2'd1, 0, d);
    check8("xrst_r1", d, 8'h00);

    // Counter wrap over 256 instructions
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      ins(LDI_, 2'(i % 4), 2'd0, 8'(i));
    end
    check8("wrap_count", bus.instr_count, 8'd0);
    op_out(2'd2, 0, d);
    check8("wrap_r2", d, 8'hFE);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
